// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared opcodes, state encoding and width for the sequential mul/div unit.
package muldiv_pkg;
    localparam int MULDIV_WIDTH = 16;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: iterative signed multiply / divide, one bit per clock on operand magnitudes,
// sign applied in FIX; results held until the next operation's FIX.
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, next;
    logic [2*WIDTH:0] acc;
    logic [WIDTH:0]   opnd;
    logic [CW-1:0]    cnt;
    logic             op_q, sign_a, neg;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem, rem_mag;
    logic [WIDTH:0]   part, rem_sh;
    logic             ge;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mag_a   = a[WIDTH-1] ? -a : a;
        mag_b   = b[WIDTH-1] ? -b : b;
        part    = acc[0] ? acc[2*WIDTH:WIDTH] + opnd : acc[2*WIDTH:WIDTH];
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        ge      = rem_sh >= opnd;
        prod    = neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        // a zero divisor skips CALC, so the dividend magnitude is still in the low half
        quo     = (opnd == '0) ? '1 : (neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_mag = (opnd == '0) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
        rem     = sign_a ? -rem_mag : rem_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        busy = state != IDLE;
        done = state == DONE;
        unique case (state)
            IDLE: next = start ? ((op == OP_DIV && b == '0) ? FIX : CALC) : IDLE;
            CALC: next = (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            FIX:  next = DONE;
            DONE: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            opnd        <= '0;
            cnt         <= '0;
            op_q        <= 1'b0;
            sign_a      <= 1'b0;
            neg         <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    sign_a <= a[WIDTH-1];
                    neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                    opnd   <= {1'b0, mag_b};
                    acc    <= {{(WIDTH + 1){1'b0}}, mag_a};
                    cnt    <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= (op_q == OP_MUL) ? {1'b0, part, acc[WIDTH-1:1]}
                                            : {ge ? rem_sh - opnd : rem_sh, acc[WIDTH-2:0], ge};
                end
                FIX: begin
                    result_lo   <= (op_q == OP_MUL) ? prod[WIDTH-1:0] : quo;
                    result_hi   <= (op_q == OP_MUL) ? prod[2*WIDTH-1:WIDTH] : rem;
                    div_by_zero <= op_q == OP_DIV && opnd == '0;
                end
                default: ;
            endcase
        end
    end
endmodule
